mio_bus_ctrl: RTL

MIO_BUS_CTRL -- requirements
Module: mio_bus_ctrl

---
 rtl/mio_bus_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mio_bus_ctrl.sv
// CPU memory/IO bus controller: decodes one word request per access and routes it
// to word RAM (multi-cycle), the LED/switch GPIO port or the timer/counter.
module mio_bus_ctrl #(
    parameter int unsigned RAM_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CPU_MIO,
    input  logic        MemRW,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Data_in,
    output logic [31:0] Cpu_data_out,
    output logic        MIO_ready,
    output logic        ram_we,
    output logic [9:0]  ram_addr,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout,
    output logic [15:0] LED_out,
    input  logic [15:0] GPIO_sw,
    output logic        counter_we,
    output logic [31:0] counter_din,
    input  logic [31:0] counter_val
);

    localparam logic [2:0] WAIT_INIT = 3'(RAM_WAIT);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {R_RAM, R_GPIO, R_CNT, R_NONE} region_t;

    typedef struct packed {
        region_t     region;
        logic        rw;
        logic [9:0]  word;
        logic [31:0] data;
    } req_t;

    state_t     state, state_d;
    logic [2:0] wait_cnt;
    req_t       req_q;
    region_t    in_region;
    logic       accept;
    logic       ram_last;

    // Byte-address decode; bits [1:0] never take part since accesses are whole words.
    always_comb begin
        in_region = R_NONE;
        if (Addr_in[31:12] == 20'h0)
            in_region = R_RAM;
        else if (Addr_in[31:2] == 30'h3C00_0000)
            in_region = R_GPIO;
        else if (Addr_in[31:2] == 30'h3C00_0001)
            in_region = R_CNT;
    end

    assign accept   = (state == IDLE) && CPU_MIO;
    assign ram_last = (state == WAIT) && (wait_cnt <= 3'd1);

    always_comb begin
        state_d    = state;
        ram_we     = 1'b0;
        counter_we = 1'b0;
        MIO_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (CPU_MIO)
                    state_d = (in_region == R_RAM) ? WAIT : DONE;
            end
            WAIT: begin
                // Counter still holds its load value only on the first wait cycle.
                ram_we = req_q.rw && (wait_cnt == WAIT_INIT);
                if (wait_cnt <= 3'd1)
                    state_d = DONE;
            end
            DONE: begin
                MIO_ready  = 1'b1;
                counter_we = req_q.rw && (req_q.region == R_CNT);
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 3'd0;
        end else begin
            state <= state_d;
            if (accept && in_region == R_RAM)
                wait_cnt <= WAIT_INIT;
            else if (state == WAIT)
                wait_cnt <= wait_cnt - 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q <= '{region: R_NONE, rw: 1'b0, word: '0, data: '0};
        end else if (accept) begin
            req_q <= '{region: in_region, rw: MemRW, word: Addr_in[11:2], data: Data_in};
        end
    end

    // Read data is committed on the cycle the request resolves; writes leave it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Cpu_data_out <= 32'h0;
            LED_out      <= 16'h0;
        end else begin
            if (accept && !MemRW) begin
                case (in_region)
                    R_GPIO:  Cpu_data_out <= {16'h0, GPIO_sw};
                    R_CNT:   Cpu_data_out <= counter_val;
                    R_NONE:  Cpu_data_out <= 32'h0;
                    default: Cpu_data_out <= Cpu_data_out;
                endcase
            end else if (ram_last && !req_q.rw) begin
                Cpu_data_out <= ram_dout;
            end
            if (accept && MemRW && in_region == R_GPIO)
                LED_out <= Data_in[15:0];
        end
    end

    assign ram_addr    = req_q.word;
    assign ram_din     = req_q.data;
    assign counter_din = req_q.data;

endmodule
